// File: rtl/inst_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_queue_if
// Description : Bundles the control, redirect, instruction-load and decode-side
//               signals of the instruction fetch queue.
//               master : the environment (front-end control, loader, decode)
//               slave  : the fetch queue itself
// Ports       : fetch_enable, stall, branch_taken, flush, pc_input[31:0],
//               load_en, load_addr[7:0], load_data[31:0]    (master -> slave)
//               first_inst[31:0], second_inst[31:0], pc_output[31:0],
//               inst_valid, queue_count[2:0]                (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_fetch_queue_if;
  logic        fetch_enable;
  logic        stall;
  logic        branch_taken;
  logic        flush;
  logic [31:0] pc_input;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic [31:0] first_inst;
  logic [31:0] second_inst;
  logic [31:0] pc_output;
  logic        inst_valid;
  logic [2:0]  queue_count;

  modport master (
    output fetch_enable, stall, branch_taken, flush, pc_input,
           load_en, load_addr, load_data,
    input  first_inst, second_inst, pc_output, inst_valid, queue_count
  );

  modport slave (
    input  fetch_enable, stall, branch_taken, flush, pc_input,
           load_en, load_addr, load_data,
    output first_inst, second_inst, pc_output, inst_valid, queue_count
  );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_queue
// Description : Dual-issue instruction fetch queue. A 256 x 32 instruction
//               memory is read two words at a time at the fetch pc; each pair
//               is pushed with its pc into a 4-entry FIFO whose head is offered
//               to decode. Branch/flush redirects clear the queue and restart
//               fetching at the (8-byte aligned) target after one dead cycle.
// Ports       : clock - rising-edge clock
//               reset - asynchronous, active-high reset
//               bus   - inst_fetch_queue_if.slave (control, load and decode
//                       signals, see the interface header)
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_queue (
  input  wire logic          clock,
  input  wire logic          reset,
  inst_fetch_queue_if.slave  bus
);

  localparam int          DEPTH       = 4;
  localparam logic [2:0]  C_FULL      = 3'd4;
  localparam logic [1:0]  ST_IDLE     = 2'd0;
  localparam logic [1:0]  ST_FETCH    = 2'd1;
  localparam logic [1:0]  ST_REDIRECT = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] first;
    logic [31:0] second;
  } entry_t;

  // --------------------------------------------------------------------------
  // Instruction memory. Not reset, so a program survives a core reset. Reads
  // are combinational off the current fetch pc, so a write on the same edge as
  // a fetch of that word lets the fetch capture the old word.
  // --------------------------------------------------------------------------
  logic [31:0] mem [0:255];

  always_ff @(posedge clock) begin
    if (bus.load_en) begin
      mem[bus.load_addr] <= bus.load_data;
    end
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]  state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [2:0]  count_q, count_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  entry_t      entry_q [DEPTH];
  entry_t      entry_d [DEPTH];

  // Decoded state flags (output process of the FSM)
  logic        in_fetch;
  logic        in_redirect;

  // Datapath control
  logic        redirect;
  logic        valid;
  logic        deq;
  logic        enq;
  logic [7:0]  word_idx0;
  logic [7:0]  word_idx1;
  entry_t      head;

  assign redirect  = bus.branch_taken | bus.flush;

  // Fetch pc is a byte address; the word index is bits [9:2]. The second word
  // index wraps modulo 256 on its own 8-bit width.
  assign word_idx0 = fpc_q[9:2];
  assign word_idx1 = word_idx0 + 8'd1;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic. A redirect wins from every state, including a
  // back-to-back redirect while already in REDIRECT.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = ST_REDIRECT;
    end else begin
      unique case (state_q)
        ST_IDLE:     if (bus.fetch_enable)  state_d = ST_FETCH;
        ST_FETCH:    if (!bus.fetch_enable) state_d = ST_IDLE;
        ST_REDIRECT: state_d = bus.fetch_enable ? ST_FETCH : ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: output decode
  // --------------------------------------------------------------------------
  always_comb begin
    in_fetch    = 1'b0;
    in_redirect = 1'b0;
    unique case (state_q)
      ST_FETCH:    in_fetch    = 1'b1;
      ST_REDIRECT: in_redirect = 1'b1;
      default:     ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Queue control. The edge that leaves FETCH (fetch_enable low) does not
  // fetch, so dropping fetch_enable freezes the fetch pc immediately. A full
  // queue still accepts a pair on an edge that also pops the head.
  // --------------------------------------------------------------------------
  assign valid = (count_q != 3'd0) && !in_redirect;
  assign deq   = valid && !bus.stall && !redirect;
  assign enq   = in_fetch && bus.fetch_enable && !redirect &&
                 ((count_q != C_FULL) || deq);

  always_comb begin
    fpc_d    = fpc_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    entry_d  = entry_q;

    if (redirect) begin
      // Pair-align the target: both slots of a pair share one 8-byte block.
      fpc_d    = bus.pc_input & ~32'h0000_0007;
      count_d  = 3'd0;
      wr_ptr_d = 2'd0;
      rd_ptr_d = 2'd0;
    end else begin
      if (enq) begin
        entry_d[wr_ptr_q] = '{pc:     fpc_q,
                              first:  mem[word_idx0],
                              second: mem[word_idx1]};
        wr_ptr_d = wr_ptr_q + 2'd1;
        fpc_d    = fpc_q + 32'd8;
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + 2'd1;
      end
      unique case ({enq, deq})
        2'b10:   count_d = count_q + 3'd1;
        2'b01:   count_d = count_q - 3'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fpc_q    <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      fpc_q    <= fpc_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      entry_q  <= entry_d;
    end
  end

  // --------------------------------------------------------------------------
  // Decode-side outputs: the head entry, forced to zero whenever nothing is
  // offered so stale FIFO contents never leak out.
  // --------------------------------------------------------------------------
  assign head            = entry_q[rd_ptr_q];
  assign bus.inst_valid  = valid;
  assign bus.queue_count = count_q;
  assign bus.first_inst  = valid ? head.first  : 32'd0;
  assign bus.second_inst = valid ? head.second : 32'd0;
  assign bus.pc_output   = valid ? head.pc     : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_queue
// Description : Directed self-checking bench for inst_fetch_queue. Inputs are
//               driven 1 ns after each rising edge and outputs are checked at
//               the same point, i.e. well away from the active edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_queue;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_pass;

  inst_fetch_queue_if bus ();

  inst_fetch_queue dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input logic [7:0] addr, input logic [31:0] data);
    bus.load_en   = 1'b1;
    bus.load_addr = addr;
    bus.load_data = data;
    tick();
    bus.load_en   = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc,
                            input logic [31:0] first, input logic [31:0] second);
    check({tag, "_valid"},  {31'd0, bus.inst_valid}, 32'd1);
    check({tag, "_pc"},     bus.pc_output,   pc);
    check({tag, "_first"},  bus.first_inst,  first);
    check({tag, "_second"}, bus.second_inst, second);
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, {31'd0, bus.inst_valid}, 32'd0);
    check({tag, "_count"}, {29'd0, bus.queue_count}, 32'd0);
    check({tag, "_pc"},    bus.pc_output,   32'd0);
    check({tag, "_first"}, bus.first_inst,  32'd0);
    check({tag, "_second"}, bus.second_inst, 32'd0);
  endtask

  initial begin
    n_checks         = 0;
    n_pass           = 0;
    reset            = 1'b1;
    bus.fetch_enable = 1'b0;
    bus.stall        = 1'b0;
    bus.branch_taken = 1'b0;
    bus.flush        = 1'b0;
    bus.pc_input     = 32'd0;
    bus.load_en      = 1'b0;
    bus.load_addr    = 8'd0;
    bus.load_data    = 32'd0;

    #3;
    check_empty("reset");
    tick();
    reset = 1'b0;

    // Program: word i = 0x11*(i+1) for i=0..15, words 254/255 = 0xFE/0xFF.
    for (int i = 0; i < 16; i++) begin
      load_word(8'(i), 32'h11 * 32'(i + 1));
    end
    load_word(8'd254, 32'hFE);
    load_word(8'd255, 32'hFF);
    check_empty("idle_after_load");

    // ---- Basic streaming with stall low ----
    bus.fetch_enable = 1'b1;
    bus.stall        = 1'b0;
    tick();                                   // E0: enter FETCH
    check("e0_valid", {31'd0, bus.inst_valid}, 32'd0);
    tick();                                   // E1: first pair enqueued
    check_head("pair0", 32'd0, 32'h11, 32'h22);
    check("pair0_count", {29'd0, bus.queue_count}, 32'd1);
    tick();
    check_head("pair1", 32'd8, 32'h33, 32'h44);
    check("pair1_count", {29'd0, bus.queue_count}, 32'd1);

    // ---- Stall fills the queue to 4, head frozen ----
    bus.flush    = 1'b1;
    bus.pc_input = 32'd0;
    bus.stall    = 1'b1;
    tick();
    bus.flush = 1'b0;
    check_empty("flush0");
    tick();                                   // REDIRECT -> FETCH
    for (int i = 0; i < 6; i++) begin
      tick();
      check("stall_count", {29'd0, bus.queue_count},
            (i + 1 > 4) ? 32'd4 : 32'(i + 1));
      check("stall_pc",    bus.pc_output,  32'd0);
      check("stall_first", bus.first_inst, 32'h11);
    end
    bus.stall = 1'b0;
    check_head("drain0", 32'd0, 32'h11, 32'h22);
    tick();
    check_head("drain8", 32'd8, 32'h33, 32'h44);
    tick();
    check_head("drain16", 32'd16, 32'h55, 32'h66);
    tick();
    check_head("drain24", 32'd24, 32'h77, 32'h88);
    check("drain_count", {29'd0, bus.queue_count}, 32'd4);

    // ---- Branch on a full queue with stall high, wrap at word 255 ----
    bus.stall = 1'b1;
    tick();
    check("full_count", {29'd0, bus.queue_count}, 32'd4);
    bus.branch_taken = 1'b1;
    bus.pc_input     = 32'h3FC;
    tick();
    bus.branch_taken = 1'b0;
    check_empty("branch");
    tick();                                   // REDIRECT -> FETCH
    check("post_redirect_count", {29'd0, bus.queue_count}, 32'd0);
    tick();
    check_head("br_pair", 32'h3F8, 32'hFE, 32'hFF);
    bus.stall = 1'b0;
    tick();
    check_head("wrap_pair", 32'h400, 32'h11, 32'h22);

    // ---- Load and fetch of word 4 on the same edge ----
    bus.flush    = 1'b1;
    bus.pc_input = 32'h10;
    bus.stall    = 1'b1;
    tick();
    bus.flush = 1'b0;
    tick();                                   // REDIRECT -> FETCH
    bus.load_en   = 1'b1;
    bus.load_addr = 8'd4;
    bus.load_data = 32'hAB;
    tick();                                   // fetch of word 4 + write
    bus.load_en = 1'b0;
    check_head("old_word", 32'h10, 32'h55, 32'h66);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    tick();
    tick();
    check_head("new_word", 32'h10, 32'hAB, 32'h66);
    check("new_word_count", {29'd0, bus.queue_count}, 32'd1);

    // ---- Asynchronous reset with 3 entries queued ----
    tick();
    tick();
    check("pre_reset_count", {29'd0, bus.queue_count}, 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check_empty("async_reset");
    tick();
    tick();
    reset = 1'b0;
    tick();                                   // IDLE -> FETCH
    check("restart_e0_valid", {31'd0, bus.inst_valid}, 32'd0);
    tick();
    check_head("restart", 32'd0, 32'h11, 32'h22);

    // ---- Drop fetch_enable with 2 entries queued ----
    tick();
    check("two_count", {29'd0, bus.queue_count}, 32'd2);
    bus.fetch_enable = 1'b0;
    tick();                                   // FETCH -> IDLE, no fetch
    check("idle_count", {29'd0, bus.queue_count}, 32'd2);
    bus.stall = 1'b0;
    check_head("idle_drain0", 32'd0, 32'h11, 32'h22);
    tick();
    check_head("idle_drain8", 32'd8, 32'h33, 32'h44);
    tick();
    check_empty("idle_drained");
    tick();
    check_empty("idle_hold");
    bus.fetch_enable = 1'b1;
    tick();
    tick();
    check_head("fpc_held", 32'd16, 32'hAB, 32'h66);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, named clock and reset as in the rest of the codebase.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- fetch_enable  in  1  permits fetching
- stall  in  1  decode cannot accept the head pair this cycle
- branch_taken  in  1  redirect to pc_input
- flush  in  1  redirect to pc_input
- pc_input  in  32  redirect target byte address
- load_en  in  1  instruction-memory write strobe
- load_addr  in  8  word index to write
- load_data  in  32  word to write
- first_inst  out  32  even-slot instruction of the head pair
- second_inst  out  32  odd-slot instruction of the head pair
- pc_output  out  32  byte address of first_inst
- inst_valid  out  1  head pair present and offered
- queue_count  out  3  occupancy, 0-4

Function
REQ-003 The block SHALL hold an internal 256 x 32-bit instruction memory, written on a rising edge when load_en=1, at load_addr.
REQ-004 A fetch at fetch pc (fpc) SHALL read words fpc[22:29] and (fpc[22:29]+1) mod 256; word-index wrap 255->0 is legal.
REQ-005 The block SHALL hold a 4-entry FIFO of {pc, first, second}.
REQ-006 The FSM states SHALL be IDLE, FETCH and REDIRECT; the state after reset SHALL be IDLE.
REQ-007 IDLE->FETCH on a clock edge with fetch_enable=1; FETCH->IDLE on a clock edge with fetch_enable=0.
REQ-008 In FETCH, on each edge where count<4, or where count=4 and a dequeue occurs, the block SHALL enqueue {fpc, mem[fpc], mem[fpc+4]} and set fpc <= fpc+8, modulo 2^32.
REQ-009 Dequeue SHALL occur on an edge with inst_valid=1 and stall=0; simultaneous enqueue and dequeue SHALL leave count unchanged.
REQ-010 inst_valid SHALL be 1 iff count>0 and state is not REDIRECT.
REQ-011 first_inst, second_inst and pc_output SHALL reflect the head entry combinationally, and SHALL be 0 when inst_valid=0.
REQ-012 branch_taken=1 or flush=1 on an edge SHALL, in any state:
- clear the FIFO;
- set fpc <= pc_input with bits [29:31] forced to 0;
- enter REDIRECT.
REQ-013 REDIRECT SHALL last exactly one cycle, with no enqueue and no dequeue, then go to FETCH if fetch_enable=1, else to IDLE.
REQ-014 A redirect SHALL take priority over stall, enqueue and dequeue in the same cycle.
REQ-015 A load and a fetch of the same word on the same edge SHALL capture the old word.
REQ-016 Latency: with fetch_enable rising before edge E0 and memory loaded, the pair at fpc SHALL be enqueued at E1 and inst_valid=1 after E1.
REQ-017 With stall held at 1, the head entry and all outputs SHALL stay constant, and the FIFO SHALL fill to 4 and then stop fetching.

Reset
REQ-018 Asserting reset SHALL immediately, without waiting for a clock edge, set:
- fpc=0, FIFO empty, state IDLE;
- inst_valid=0, queue_count=0, first_inst=0, second_inst=0, pc_output=0.
REQ-019 Reset SHALL NOT clear the instruction memory contents.
REQ-020 Reset asserted mid-fetch or mid-redirect SHALL discard all in-flight entries; fetching SHALL restart from pc 0 after the first edge with reset=0 and fetch_enable=1.

Verification
REQ-021 Load mem[0..3] = 0x11, 0x22, 0x33, 0x44; raise fetch_enable, stall=0 -> first=0x11, second=0x22, pc_output=0 one edge after FETCH entry; next cycle first=0x33, second=0x44, pc_output=8.
REQ-022 Hold stall=1 for 6 cycles -> queue_count climbs to 4 and holds; outputs stay pc_output=0, first=0x11; on release, pairs appear in order pc 0, 8, 16, 24.
REQ-023 FIFO full, branch_taken=1, pc_input=0x3FC, stall=1 same cycle -> queue_count=0 and inst_valid=0 for one cycle; next pair has pc_output=0x3F8 with words 254 and 255; the following pair wraps to words 0 and 1.
REQ-024 load_en to word 4 with load_data=0xAB on the same edge that fetches word 4 (old value 0x55) -> fetched first=0x55; a later refetch after flush to pc_input=0x10 returns 0xAB.
REQ-025 Pulse reset during FETCH with 3 entries queued -> all outputs 0 immediately; after release, the first pair again has pc_output=0.
REQ-026 Drop fetch_enable with 2 entries queued -> state IDLE, both entries still drain in order, then inst_valid=0 and fpc holds its value.
